// File: rtl/fir_mac_tdm.sv
// Time-multiplexed multi-channel FIR: one delay line per channel, double-buffered
// coefficients, 4-stage pipeline (accept, multiply, add, round/saturate).
module fir_mac_tdm #(
  parameter int TAPS  = 5,
  parameter int DW    = 8,
  parameter int CW    = 16,
  parameter int CH    = 3,
  parameter int OW    = 16,
  parameter int SHIFT = 8,
  localparam int AW   = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_commit,
  input  logic                 in_valid,
  input  logic [CHW-1:0]       in_ch,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [OW-1:0] out_data,
  output logic                 out_sat
);

  localparam int PW = CW + DW + 1;              // product width
  localparam int SW = PW + $clog2(TAPS);        // adder-tree width, cannot overflow
  localparam int RW = SW + 1;                   // headroom for the rounding constant
  localparam int XW = (RW > OW) ? RW : OW + 1;  // comparison width for saturation

  localparam logic signed [RW-1:0] RND  = ({{(RW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [XW-1:0] MAXV = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [DW-1:0]        dline [CH][TAPS];
  logic signed [CW-1:0] coef_sh  [TAPS];
  logic signed [CW-1:0] coef_act [TAPS];

  logic                 accept;
  logic [DW-1:0]        shift_taps [TAPS];

  logic                 s1_valid, s2_valid, s3_valid;
  logic [CHW-1:0]       s1_ch, s2_ch, s3_ch;
  logic [DW-1:0]        s1_taps [TAPS];
  logic signed [PW-1:0] prod    [TAPS];
  logic signed [PW-1:0] s2_prod [TAPS];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] s3_sum;
  logic signed [RW-1:0] rounded;
  logic signed [XW-1:0] rounded_x;
  logic signed [OW-1:0] sat_data;
  logic                 sat_flag;

  assign accept = in_valid && (int'(in_ch) < CH);

  // Post-shift view of the addressed channel's delay line.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    for (int k = 0; k < TAPS; k++) shift_taps[k] = '0;
    shift_taps[0] = in_data;
    for (int c = 0; c < CH; c++) begin
      if (in_ch == CHW'(c)) begin
        for (int k = 1; k < TAPS; k++) shift_taps[k] = dline[c][k-1];
      end
    end
  end

  // NOTE: delay lines and coefficient banks are reset because post-reset results must see zero history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < TAPS; k++) dline[c][k] <= '0;
      for (int k = 0; k < TAPS; k++) begin
        coef_sh[k]  <= '0;
        coef_act[k] <= '0;
      end
    end else begin
      if (accept) begin
        for (int c = 0; c < CH; c++)
          if (in_ch == CHW'(c))
            for (int k = 0; k < TAPS; k++) dline[c][k] <= shift_taps[k];
      end
      // Out-of-range addresses match no slot; a commit copies the pre-write shadow.
      for (int k = 0; k < TAPS; k++)
        if (coef_we && coef_addr == AW'(k)) coef_sh[k] <= coef_data;
      if (coef_commit) coef_act <= coef_sh;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_ch    <= '0;
      s2_ch    <= '0;
      s3_ch    <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (accept) s1_ch <= in_ch;
      s2_ch <= s1_ch;
      s3_ch <= s2_ch;
    end
  end

  // Datapath registers are qualified by the valid chain, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) s1_taps <= shift_taps;
    s2_prod <= prod;
    s3_sum  <= sum;
  end

  // S1 uses the active bank as it stands in the cycle after acceptance.
  always_comb begin
    for (int k = 0; k < TAPS; k++)
      prod[k] = PW'($signed({1'b0, s1_taps[k]})) * PW'(coef_act[k]);
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + SW'(s2_prod[k]);
  end

  always_comb begin
    rounded   = (RW'(s3_sum) + RND) >>> SHIFT;
    rounded_x = XW'(rounded);
    sat_data  = rounded_x[OW-1:0];
    sat_flag  = 1'b0;
    if (rounded_x > MAXV) begin
      sat_data = MAXV[OW-1:0];
      sat_flag = 1'b1;
    end else if (rounded_x < MINV) begin
      sat_data = MINV[OW-1:0];
      sat_flag = 1'b1;
    end
  end

  // Result fields hold their last value while no result is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_ch   <= s3_ch;
        out_data <= sat_data;
        out_sat  <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_tdm.sv
// Directed bench for fir_mac_tdm: two instances (SHIFT=0 and SHIFT=8) share one
// input stream; each task drives a scenario and compares against hand-computed values.
module tb_fir_mac_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_commit;
  logic               in_valid;
  logic [1:0]         in_ch;
  logic [7:0]         in_data;

  logic               o0_valid, o8_valid;
  logic [1:0]         o0_ch, o8_ch;
  logic signed [15:0] o0_data, o8_data;
  logic               o0_sat, o8_sat;

  fir_mac_tdm #(.TAPS(5), .DW(8), .CW(16), .CH(3), .OW(16), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .out_valid(o0_valid), .out_ch(o0_ch), .out_data(o0_data), .out_sat(o0_sat)
  );

  fir_mac_tdm #(.TAPS(5), .DW(8), .CW(16), .CH(3), .OW(16), .SHIFT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .out_valid(o8_valid), .out_ch(o8_ch), .out_data(o8_data), .out_sat(o8_sat)
  );

  typedef struct {
    logic               v;
    logic [1:0]         ch;
    logic signed [15:0] d;
    logic               sat;
  } obs_t;

  obs_t q0[$];
  obs_t q8[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input cycle; records both instances' outputs sampled 1 ns after the edge.
  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic cm);
    in_valid    = v;
    in_ch       = ch;
    in_data     = d;
    coef_commit = cm;
    tick();
    in_valid    = 1'b0;
    coef_commit = 1'b0;
    q0.push_back('{o0_valid, o0_ch, o0_data, o0_sat});
    q8.push_back('{o8_valid, o8_ch, o8_data, o8_sat});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  task automatic set_coefs(input int c[5], input logic commit);
    for (int k = 0; k < 5; k++) begin
      coef_we   = 1'b1;
      coef_addr = 3'(k);
      coef_data = 16'(c[k]);
      tick();
    end
    coef_we = 1'b0;
    if (commit) begin
      coef_commit = 1'b1;
      tick();
      coef_commit = 1'b0;
    end
  endtask

  task automatic clear_q();
    q0.delete();
    q8.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    in_valid = 1'b0; in_ch = '0; in_data = '0;
    repeat (2) tick();
    total++; if (o0_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", o0_valid); end
    total++; if (o0_data !== 16'sd0) begin bad++; $display("FAIL reset out_data: got %0d want 0", o0_data); end
    total++; if (o0_ch !== 2'd0) begin bad++; $display("FAIL reset out_ch: got %0d want 0", o0_ch); end
    total++; if (o8_sat !== 1'b0) begin bad++; $display("FAIL reset out_sat: got %b want 0", o8_sat); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    int exp_d[6] = '{1, 2, 3, 4, 5, 0};
    set_coefs('{1, 2, 3, 4, 5}, 1'b1);
    clear_q();
    drive(1'b1, 2'd0, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd0, 8'd0, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q0[i].v !== 1'b0) begin bad++; $display("FAIL impulse early valid[%0d]: got %b want 0", i, q0[i].v); end
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (q0[i+3].v !== 1'b1 || q0[i+3].ch !== 2'd0 || q0[i+3].d !== 16'(exp_d[i]))
        begin bad++; $display("FAIL impulse[%0d]: got v=%b ch=%0d d=%0d want v=1 ch=0 d=%0d",
                              i, q0[i+3].v, q0[i+3].ch, q0[i+3].d, exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back_channels();
    logic exp_v[16];
    int   exp_ch[16];
    int   exp_d[16];
    int   j = 0;
    set_coefs('{1, 1, 1, 1, 1}, 1'b1);
    clear_q();
    for (int r = 1; r <= 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        drive(1'b1, 2'(c), 8'((c + 1) * 10), 1'b0);
        exp_v[j] = 1'b1; exp_ch[j] = c; exp_d[j] = (c + 1) * 10 * r; j++;
      end
      if (r == 2) begin
        drive(1'b1, 2'd3, 8'd99, 1'b0);
        exp_v[j] = 1'b0; exp_ch[j] = 0; exp_d[j] = 0; j++;
      end
    end
    idle(4);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (!exp_v[i]) begin
        if (q0[i+3].v !== 1'b0) begin bad++; $display("FAIL dropped ch3 slot %0d: got v=%b want 0", i, q0[i+3].v); end
      end else if (q0[i+3].v !== 1'b1 || q0[i+3].ch !== 2'(exp_ch[i]) || q0[i+3].d !== 16'(exp_d[i])) begin
        bad++; $display("FAIL channels[%0d]: got v=%b ch=%0d d=%0d want v=1 ch=%0d d=%0d",
                        i, q0[i+3].v, q0[i+3].ch, q0[i+3].d, exp_ch[i], exp_d[i]);
      end
    end
    total++;
    if (q0[19].v !== 1'b0 || q0[19].ch !== 2'd2 || q0[19].d !== 16'sd150)
      begin bad++; $display("FAIL hold after last: got v=%b ch=%0d d=%0d want v=0 ch=2 d=150",
                            q0[19].v, q0[19].ch, q0[19].d); end
  endtask

  task automatic test_saturation();
    set_coefs('{32767, 32767, 32767, 32767, 32767}, 1'b1);
    clear_q();
    repeat (5) drive(1'b1, 2'd0, 8'd255, 1'b0);
    idle(3);
    total++;
    if (q8[7].v !== 1'b1 || q8[7].d !== 16'sd32767 || q8[7].sat !== 1'b1)
      begin bad++; $display("FAIL sat positive: got v=%b d=%0d sat=%b want v=1 d=32767 sat=1",
                            q8[7].v, q8[7].d, q8[7].sat); end
    set_coefs('{-32768, -32768, -32768, -32768, -32768}, 1'b1);
    clear_q();
    repeat (5) drive(1'b1, 2'd0, 8'd255, 1'b0);
    idle(3);
    total++;
    if (q8[7].v !== 1'b1 || q8[7].d !== 16'sh8000 || q8[7].sat !== 1'b1)
      begin bad++; $display("FAIL sat negative: got v=%b d=%0d sat=%b want v=1 d=-32768 sat=1",
                            q8[7].v, q8[7].d, q8[7].sat); end
  endtask

  task automatic test_rounding();
    int c0s[4]  = '{128, 127, -128, -129};
    int exp8[4] = '{1, 0, 0, -1};
    int c[5];
    for (int i = 0; i < 4; i++) begin
      c = '{c0s[i], 0, 0, 0, 0};
      set_coefs(c, 1'b1);
      clear_q();
      drive(1'b1, 2'd0, 8'd1, 1'b0);
      idle(3);
      total++;
      if (q8[3].v !== 1'b1 || q8[3].d !== 16'(exp8[i]) || q8[3].sat !== 1'b0)
        begin bad++; $display("FAIL round c0=%0d: got v=%b d=%0d sat=%b want v=1 d=%0d sat=0",
                              c0s[i], q8[3].v, q8[3].d, q8[3].sat, exp8[i]); end
      total++;
      if (q0[3].d !== 16'(c0s[i]))
        begin bad++; $display("FAIL noshift c0=%0d: got d=%0d want %0d", c0s[i], q0[3].d, c0s[i]); end
    end
  endtask

  task automatic test_commit_timing();
    set_coefs('{1, 0, 0, 0, 0}, 1'b1);
    set_coefs('{2, 0, 0, 0, 0}, 1'b0);
    clear_q();
    drive(1'b1, 2'd0, 8'd5, 1'b0);
    drive(1'b1, 2'd0, 8'd5, 1'b1);
    idle(3);
    total++;
    if (q0[3].v !== 1'b1 || q0[3].d !== 16'sd5)
      begin bad++; $display("FAIL commit old bank: got v=%b d=%0d want v=1 d=5", q0[3].v, q0[3].d); end
    total++;
    if (q0[4].v !== 1'b1 || q0[4].d !== 16'sd10)
      begin bad++; $display("FAIL commit same cycle: got v=%b d=%0d want v=1 d=10", q0[4].v, q0[4].d); end

    // Write and commit together: active takes the pre-write shadow (2).
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd3; coef_commit = 1'b1;
    tick();
    coef_we = 1'b0; coef_commit = 1'b0;
    clear_q();
    drive(1'b1, 2'd0, 8'd5, 1'b0);
    idle(3);
    total++;
    if (q0[3].d !== 16'sd10)
      begin bad++; $display("FAIL we+commit: got d=%0d want 10", q0[3].d); end

    // Out-of-range address is ignored; commit then exposes shadow [3,0,0,0,0].
    coef_we = 1'b1; coef_addr = 3'd5; coef_data = 16'sd100;
    tick();
    coef_we = 1'b0; coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    clear_q();
    drive(1'b1, 2'd0, 8'd5, 1'b0);
    idle(3);
    total++;
    if (q0[3].d !== 16'sd15)
      begin bad++; $display("FAIL addr out of range: got d=%0d want 15", q0[3].d); end
  endtask

  task automatic test_reset_mid_stream();
    drive(1'b1, 2'd0, 8'd1, 1'b0);
    drive(1'b1, 2'd1, 8'd2, 1'b0);
    drive(1'b1, 2'd2, 8'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (o0_valid !== 1'b0 || o0_data !== 16'sd0 || o0_ch !== 2'd0 || o0_sat !== 1'b0)
      begin bad++; $display("FAIL mid reset outputs: got v=%b ch=%0d d=%0d sat=%b want all 0",
                            o0_valid, o0_ch, o0_data, o0_sat); end
    tick();
    rst_n = 1'b1;
    clear_q();
    idle(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (q0[i].v !== 1'b0 || q8[i].v !== 1'b0)
        begin bad++; $display("FAIL post reset valid[%0d]: got %b/%b want 0", i, q0[i].v, q8[i].v); end
    end
    clear_q();
    drive(1'b1, 2'd1, 8'd7, 1'b0);
    idle(3);
    total++;
    if (q0[3].v !== 1'b1 || q0[3].ch !== 2'd1 || q0[3].d !== 16'sd0)
      begin bad++; $display("FAIL post reset sample: got v=%b ch=%0d d=%0d want v=1 ch=1 d=0",
                            q0[3].v, q0[3].ch, q0[3].d); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back_channels();
    test_saturation();
    test_rounding();
    test_commit_timing();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
